mem_arbiter: RTL and testbench

Sequencer and arbiter for the CPU's single byte-wide RAM/IO port. It shares that port between the instruction-fetch unit (4-byte reads) and the load/store unit (1/2/4-byte reads and writes). It serialises each request into per-byte memory cycles, honours the IO write back-pressure, and supports abort of in-flight fetches on pipeline clear. It sits inside the CPU core, between the fetch/LS units and the top-level `mem_*` pins.

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the byte-wide memory port arbiter
package mem_arbiter_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] IO_SEL = 2'b11;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;
  function automatic logic [2:0] len_of(input logic [1:0] size);
    return size == SZ_B ? 3'd1 : size == SZ_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and load/store requests onto the byte-wide RAM/IO port
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        clear_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);
  state_t state;
  owner_t owner, last;
  logic [1:0] cnt, nxt;
  logic [2:0] len;
  logic [31:0] addr, wdata, acc, merged;
  logic mem_wr_r, if_ok, ls_ok, grant_if, grant_ls, fin;
  assign mem_wr = mem_wr_r & rdy_in;
  // eligibility, round-robin tie break and byte-lane merge of the incoming read byte
  always_comb begin
    nxt = cnt + 2'd1;
    fin = {1'b0, cnt} == len - 3'd1;
    if_ok = if_req & ~clear_in;
    ls_ok = ls_req & ~(ls_we & io_buffer_full & (ls_addr[17:16] == IO_SEL));
    grant_ls = ls_ok & (~if_ok | (last == OWN_IF));
    grant_if = if_ok & ~grant_ls;
    merged = acc;
    merged[8*cnt +: 8] = mem_din;
  end
  // single sequencer: grant in IDLE, then one byte per cycle until the length is exhausted
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= IDLE;
      owner <= OWN_IF;
      last <= OWN_IF;
      cnt <= 2'd0;
      len <= 3'd0;
      addr <= 32'd0;
      wdata <= 32'd0;
      acc <= 32'd0;
      mem_a <= 32'd0;
      mem_dout <= 8'd0;
      mem_wr_r <= 1'b0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
      if_data <= 32'd0;
      ls_rdata <= 32'd0;
    end else if (rdy_in) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        IDLE: if (grant_if || grant_ls) begin
          owner <= grant_ls ? OWN_LS : OWN_IF;
          last <= grant_ls ? OWN_LS : OWN_IF;
          addr <= grant_ls ? ls_addr : if_addr;
          len <= grant_ls ? len_of(ls_size) : 3'd4;
          wdata <= ls_wdata;
          state <= (grant_ls && ls_we) ? WRITE : READ;
          cnt <= 2'd0;
          acc <= 32'd0;
          mem_a <= grant_ls ? ls_addr : if_addr;
          mem_wr_r <= grant_ls & ls_we;
          mem_dout <= (grant_ls && ls_we) ? ls_wdata[7:0] : 8'd0;
        end
        READ: if (owner == OWN_IF && clear_in) begin
          state <= IDLE;
          mem_a <= 32'd0;
        end else if (fin) begin
          state <= IDLE;
          mem_a <= 32'd0;
          if (owner == OWN_IF) begin
            if_done <= 1'b1;
            if_data <= merged;
          end else begin
            ls_done <= 1'b1;
            ls_rdata <= merged;
          end
        end else begin
          acc <= merged;
          cnt <= nxt;
          mem_a <= addr + {30'd0, nxt};
        end
        WRITE: if (fin) begin
          state <= IDLE;
          mem_a <= 32'd0;
          mem_dout <= 8'd0;
          mem_wr_r <= 1'b0;
          ls_done <= 1'b1;
        end else begin
          cnt <= nxt;
          mem_a <= addr + {30'd0, nxt};
          mem_dout <= wdata[8*nxt +: 8];
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for the memory port arbiter
module tb_mem_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear_in, io_buffer_full, if_req, ls_req, ls_we;
  logic mem_wr, if_done, ls_done;
  logic [7:0] mem_din, mem_dout;
  logic [31:0] mem_a, if_addr, ls_addr, ls_wdata, if_data, ls_rdata;
  logic [1:0] ls_size;
  int checks = 0, errors = 0, cyc = 0, done_rd = 0, wr_rd = 0;
  typedef struct {bit own; bit chk; logic [31:0] data;} exp_t;
  typedef struct {bit own; logic [31:0] data; int cyc;} obs_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  exp_t exp_q[$];
  wr_t wexp_q[$];
  obs_t done_q[$];
  wr_t wr_q[$];
  logic [7:0] wmem [logic [31:0]];

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .clear_in(clear_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h200: return 8'h11;
      32'h201: return 8'h22;
      32'h202: return 8'h33;
      32'h203: return 8'h44;
      32'h400: return 8'h12;
      32'h401: return 8'h34;
      default: return 8'h00;
    endcase
  endfunction

  // memory model and output monitor; a write commits at the edge following this sample
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (if_done) done_q.push_back('{1'b0, if_data, cyc});
      if (ls_done) done_q.push_back('{1'b1, ls_rdata, cyc});
      if (mem_wr) begin
        wmem[mem_a] = mem_dout;
        wr_q.push_back('{mem_a, mem_dout});
      end
    end
    mem_din = wmem.exists(mem_a) ? wmem[mem_a] : init_byte(mem_a);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run(input int max);
    for (int i = 0; i < max && (if_req || ls_req); i++) begin
      tick();
      if (if_done) if_req = 1'b0;
      if (ls_done) ls_req = 1'b0;
    end
    tick();
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; if_addr = '0; ls_addr = '0;
    ls_size = 2'd0; ls_wdata = '0;
    repeat (3) tick();
    checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a got %h exp 0", mem_a); end
    checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout got %h exp 0", mem_dout); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
    checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done got %b exp 0", if_done); end
    checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL reset_ls_done got %b exp 0", ls_done); end
    checks++; if (if_data !== 32'd0) begin errors++; $display("FAIL reset_if_data got %h exp 0", if_data); end
    checks++; if (ls_rdata !== 32'd0) begin errors++; $display("FAIL reset_ls_rdata got %h exp 0", ls_rdata); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int g;
    exp_t e;
    obs_t o;
    if_addr = 32'h100; if_req = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 32'h0000_0513});
    tick();
    g = cyc;
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL fetch_mem_wr got %b exp 0", mem_wr); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checks++;
      if (mem_a !== 32'h100 + k) begin errors++; $display("FAIL fetch_addr%0d got %h exp %h", k, mem_a, 32'h100 + k); end
    end
    run(10);
    checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL fetch_idle_addr got %h exp 0", mem_a); end
    e = exp_q.pop_front();
    checks++;
    if (done_rd >= done_q.size()) begin errors++; $display("FAIL fetch_done missing, exp data %h", e.data); end
    else begin
      o = done_q[done_rd++];
      if (o.own !== e.own || o.data !== e.data) begin errors++; $display("FAIL fetch_done got own %0d data %h exp own %0d data %h", o.own, o.data, e.own, e.data); end
      checks++;
      if (o.cyc - g !== 4) begin errors++; $display("FAIL fetch_latency got %0d exp 4", o.cyc - g); end
    end
  endtask

  task automatic test_arbitration();
    int g;
    int c[$];
    exp_t e;
    obs_t o;
    if_addr = 32'h100; if_req = 1'b1;
    ls_addr = 32'h200; ls_we = 1'b0; ls_size = 2'd2; ls_req = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 32'h4433_2211});
    exp_q.push_back('{1'b0, 1'b1, 32'h0000_0513});
    tick();
    g = cyc;
    checks++; if (mem_a !== 32'h200) begin errors++; $display("FAIL arb_tie1 got addr %h exp 200", mem_a); end
    run(30);
    ls_addr = 32'h202; ls_size = 2'd1; ls_req = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 32'h0000_4433});
    run(10);
    if_addr = 32'h100; if_req = 1'b1;
    ls_addr = 32'h201; ls_size = 2'd0; ls_req = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 32'h0000_0513});
    exp_q.push_back('{1'b1, 1'b1, 32'h0000_0022});
    tick();
    checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL arb_tie2 got addr %h exp 100", mem_a); end
    run(30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (done_rd >= done_q.size()) begin errors++; $display("FAIL arb_done missing own %0d data %h", e.own, e.data); end
      else begin
        o = done_q[done_rd++];
        c.push_back(o.cyc);
        if (o.own !== e.own || o.data !== e.data) begin errors++; $display("FAIL arb_done got own %0d data %h exp own %0d data %h", o.own, o.data, e.own, e.data); end
      end
    end
    checks++;
    if (c.size() < 2 || c[0] - g !== 4 || c[1] - g !== 9) begin errors++; $display("FAIL arb_timing got %0d entries, exp done offsets 4 and 9", c.size()); end
  endtask

  task automatic test_io_store();
    exp_t e;
    obs_t o;
    wr_t w, x;
    ls_addr = 32'h30000; ls_we = 1'b1; ls_size = 2'd0; ls_wdata = 32'h1234_5641;
    io_buffer_full = 1'b1; ls_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (mem_wr !== 1'b0 || mem_a !== 32'd0) begin errors++; $display("FAIL io_blocked cycle %0d got wr %b addr %h exp 0", i, mem_wr, mem_a); end
    end
    io_buffer_full = 1'b0;
    exp_q.push_back('{1'b1, 1'b0, 32'd0});
    wexp_q.push_back('{32'h30000, 8'h41});
    run(10);
    ls_we = 1'b0;
    checks++;
    if (wr_q.size() - wr_rd !== 1) begin errors++; $display("FAIL io_write_count got %0d exp 1", wr_q.size() - wr_rd); end
    while (wexp_q.size() > 0) begin
      x = wexp_q.pop_front();
      checks++;
      if (wr_rd >= wr_q.size()) begin errors++; $display("FAIL io_write missing exp %h@%h", x.d, x.a); end
      else begin
        w = wr_q[wr_rd++];
        if (w.a !== x.a || w.d !== x.d) begin errors++; $display("FAIL io_write got %h@%h exp %h@%h", w.d, w.a, x.d, x.a); end
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (done_rd >= done_q.size()) begin errors++; $display("FAIL io_done missing"); end
    else begin
      o = done_q[done_rd++];
      if (o.own !== e.own) begin errors++; $display("FAIL io_done got own %0d exp %0d", o.own, e.own); end
    end
  endtask

  task automatic test_half_store();
    int g;
    exp_t e;
    obs_t o;
    wr_t w, x;
    ls_addr = 32'h3FE; ls_we = 1'b1; ls_size = 2'd1; ls_wdata = 32'hDEAD_BEEF; ls_req = 1'b1;
    exp_q.push_back('{1'b1, 1'b0, 32'd0});
    wexp_q.push_back('{32'h3FE, 8'hEF});
    wexp_q.push_back('{32'h3FF, 8'hBE});
    tick();
    g = cyc;
    run(10);
    ls_we = 1'b0;
    while (wexp_q.size() > 0) begin
      x = wexp_q.pop_front();
      checks++;
      if (wr_rd >= wr_q.size()) begin errors++; $display("FAIL half_write missing exp %h@%h", x.d, x.a); end
      else begin
        w = wr_q[wr_rd++];
        if (w.a !== x.a || w.d !== x.d) begin errors++; $display("FAIL half_write got %h@%h exp %h@%h", w.d, w.a, x.d, x.a); end
      end
    end
    checks++;
    if (wr_q.size() != wr_rd) begin errors++; $display("FAIL half_extra_writes got %0d exp 0", wr_q.size() - wr_rd); end
    ls_addr = 32'h3FE; ls_size = 2'd2; ls_req = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 32'h3412_BEEF});
    run(10);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (done_rd >= done_q.size()) begin errors++; $display("FAIL half_done%0d missing", i); end
      else begin
        o = done_q[done_rd++];
        if (o.own !== e.own || (e.chk && o.data !== e.data)) begin errors++; $display("FAIL half_done%0d got own %0d data %h exp own %0d data %h", i, o.own, o.data, e.own, e.data); end
        if (i == 0) begin
          checks++;
          if (o.cyc - g !== 2) begin errors++; $display("FAIL half_latency got %0d exp 2", o.cyc - g); end
        end
      end
    end
  endtask

  task automatic test_clear();
    int g;
    exp_t e;
    obs_t o;
    if_addr = 32'h100; if_req = 1'b1;
    tick();
    g = cyc;
    tick();
    tick();
    checks++; if (mem_a !== 32'h102) begin errors++; $display("FAIL clear_byte2 got addr %h exp 102", mem_a); end
    clear_in = 1'b1; if_req = 1'b0;
    ls_addr = 32'h200; ls_we = 1'b0; ls_size = 2'd0; ls_req = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 32'h0000_0011});
    tick();
    checks++;
    if (mem_a !== 32'd0 || mem_wr !== 1'b0 || if_done !== 1'b0) begin errors++; $display("FAIL clear_idle got addr %h wr %b if_done %b exp 0 0 0", mem_a, mem_wr, if_done); end
    clear_in = 1'b0;
    tick();
    checks++; if (mem_a !== 32'h200) begin errors++; $display("FAIL clear_ls_grant got addr %h exp 200", mem_a); end
    run(10);
    e = exp_q.pop_front();
    checks++;
    if (done_rd >= done_q.size()) begin errors++; $display("FAIL clear_done missing"); end
    else begin
      o = done_q[done_rd++];
      if (o.own !== e.own || o.data !== e.data || o.cyc - g !== 5) begin errors++; $display("FAIL clear_done got own %0d data %h at +%0d exp own %0d data %h at +5", o.own, o.data, o.cyc - g, e.own, e.data); end
    end
    checks++;
    if (done_q.size() != done_rd) begin errors++; $display("FAIL clear_extra_done got %0d exp 0", done_q.size() - done_rd); end
  endtask

  task automatic test_rdy_stall();
    exp_t e;
    obs_t o;
    wr_t w, x;
    logic [31:0] d = 32'hA1B2_C3D4;
    ls_addr = 32'h500; ls_we = 1'b1; ls_size = 2'd2; ls_wdata = d; ls_req = 1'b1;
    exp_q.push_back('{1'b1, 1'b0, 32'd0});
    for (int k = 0; k < 4; k++) wexp_q.push_back('{32'h500 + k, d[8*k +: 8]});
    tick();
    checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'hD4) begin errors++; $display("FAIL rdy_first got wr %b dout %h exp 1 d4", mem_wr, mem_dout); end
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_wr !== 1'b0 || mem_a !== 32'h501) begin errors++; $display("FAIL rdy_hold cycle %0d got wr %b addr %h exp 0 501", i, mem_wr, mem_a); end
    end
    rdy_in = 1'b1;
    run(10);
    ls_we = 1'b0;
    checks++;
    if (wr_q.size() - wr_rd !== 4) begin errors++; $display("FAIL rdy_write_count got %0d exp 4", wr_q.size() - wr_rd); end
    while (wexp_q.size() > 0) begin
      x = wexp_q.pop_front();
      checks++;
      if (wr_rd >= wr_q.size()) begin errors++; $display("FAIL rdy_write missing exp %h@%h", x.d, x.a); end
      else begin
        w = wr_q[wr_rd++];
        if (w.a !== x.a || w.d !== x.d) begin errors++; $display("FAIL rdy_write got %h@%h exp %h@%h", w.d, w.a, x.d, x.a); end
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (done_rd >= done_q.size()) begin errors++; $display("FAIL rdy_done missing"); end
    else begin
      o = done_q[done_rd++];
      if (o.own !== e.own) begin errors++; $display("FAIL rdy_done got own %0d exp %0d", o.own, e.own); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_arbitration();
    test_io_store();
    test_half_store();
    test_clear();
    test_rdy_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
